// File: rtl/led_pkg.sv
// +----------------------------------------------------------------------------+
// | led_pkg: shared widths and defaults for the LED fade/PWM stage.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package led_pkg;
    localparam int LED_N        = 8;
    localparam int PWM_W        = 8;
    localparam int FADE_DIV_DEF = 65536;

    typedef logic [PWM_W-1:0] duty_t;
endpackage

`default_nettype wire

// File: rtl/fade_chan.sv
// +----------------------------------------------------------------------------+
// | fade_chan: one LED channel - duty register with linear afterglow and PWM.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fade_chan #(
    parameter int CNT_W     = 8,
    parameter int FADE_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pattern_bit,
    input  logic [CNT_W-1:0] bright,
    input  logic             fade_en,
    input  logic             tick,
    input  logic [CNT_W-1:0] pwm_cnt,
    output logic [CNT_W-1:0] duty,
    output logic             led
);
    localparam logic [CNT_W-1:0] c_step = CNT_W'(FADE_STEP);

    logic [CNT_W-1:0] r_duty;
    logic [CNT_W-1:0] w_dec;

    // Saturating decrement so a fading channel never wraps back to bright.
    assign w_dec = (r_duty > c_step) ? (r_duty - c_step) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty <= '0;
            led    <= 1'b0;
        end else begin
            if (pattern_bit) begin
                r_duty <= bright;
            end else if (!fade_en) begin
                r_duty <= '0;
            end else if (tick) begin
                r_duty <= w_dec;
            end
            led <= (r_duty > pwm_cnt);
        end
    end

    assign duty = r_duty;
endmodule

`default_nettype wire

// File: rtl/led_fade_pwm.sv
// +----------------------------------------------------------------------------+
// | led_fade_pwm: PWM dimming with per-LED afterglow for the pattern word.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module led_fade_pwm
    import led_pkg::*;
#(
    parameter int N         = LED_N,
    parameter int CNT_W     = PWM_W,
    parameter int FADE_DIV  = FADE_DIV_DEF,
    parameter int FADE_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     pattern_in,
    input  logic [CNT_W-1:0] bright,
    input  logic             fade_en,
    output logic [N-1:0]     led_out,
    output logic             active
);
    localparam int               c_div_w    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(FADE_DIV - 1);

    logic [CNT_W-1:0]   r_pwm_cnt;
    logic [c_div_w-1:0] r_div_cnt;
    logic               w_tick;
    logic [N-1:0]       w_nonzero;

    assign w_tick = (r_div_cnt == c_div_last);

    // Prescaler free-runs; a fall never restarts it, so the first fade step
    // lands anywhere within one prescaler period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= '0;
            r_div_cnt <= '0;
            active    <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_div_cnt <= w_tick ? '0 : (r_div_cnt + 1'b1);
            active    <= |w_nonzero;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_chan
        logic [CNT_W-1:0] w_duty;

        fade_chan #(
            .CNT_W     (CNT_W),
            .FADE_STEP (FADE_STEP)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .pattern_bit (pattern_in[i]),
            .bright      (bright),
            .fade_en     (fade_en),
            .tick        (w_tick),
            .pwm_cnt     (r_pwm_cnt),
            .duty        (w_duty),
            .led         (led_out[i])
        );

        assign w_nonzero[i] = (w_duty != '0);
    end
endmodule

`default_nettype wire

// File: tb/tb_led_fade_pwm.sv
// +----------------------------------------------------------------------------+
// | tb_led_fade_pwm: directed self-checking bench, CNT_W=4, FADE_DIV=4.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_led_fade_pwm;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pattern_in = 8'h00;
    logic [3:0] bright = 4'd0;
    logic       fade_en = 1'b0;
    logic [7:0] led_out;
    logic       active;

    logic [7:0] pattern4 = 8'h00;
    logic [3:0] bright4 = 4'd0;
    logic       fade_en4 = 1'b1;
    logic [7:0] led_out4;
    logic       active4;

    int n_cmp  = 0;
    int n_fail = 0;
    int edge_n;

    led_fade_pwm #(.N(8), .CNT_W(4), .FADE_DIV(4), .FADE_STEP(1)) dut (
        .clk(clk), .rst(rst), .pattern_in(pattern_in), .bright(bright),
        .fade_en(fade_en), .led_out(led_out), .active(active)
    );

    led_fade_pwm #(.N(8), .CNT_W(4), .FADE_DIV(4), .FADE_STEP(4)) dut4 (
        .clk(clk), .rst(rst), .pattern_in(pattern4), .bright(bright4),
        .fade_en(fade_en4), .led_out(led_out4), .active(active4)
    );

    always #5 clk = ~clk;

    // Edges since reset release; pwm_cnt after an edge equals edge_n mod 16.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int pwm_prev();
        return (edge_n + 15) % 16;
    endfunction

    task automatic test_reset();
        step(2);
        n_cmp++;
        if ({led_out, active} !== 9'h000) begin
            n_fail++; $display("FAIL reset_state: got led=%h act=%b want led=00 act=0", led_out, active);
        end
        rst = 1'b0;
        pattern_in = 8'hFF; bright = 4'd15;
        step(3);
        n_cmp++;
        if (led_out !== 8'hFF) begin
            n_fail++; $display("FAIL reset_pre_on: got %h want ff", led_out);
        end
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({led_out, active} !== 9'h000) begin
            n_fail++; $display("FAIL reset_async: got led=%h act=%b want led=00 act=0", led_out, active);
        end
        n_cmp++;
        if (dut.g_chan[0].u_chan.r_duty !== 4'd0) begin
            n_fail++; $display("FAIL reset_duty: got %0d want 0", dut.g_chan[0].u_chan.r_duty);
        end
        #2;
        rst = 1'b0;
        step(1);
        n_cmp++;
        if ({led_out, active} !== 9'h000) begin
            n_fail++; $display("FAIL reset_edge1: got led=%h act=%b want led=00 act=0", led_out, active);
        end
        step(1);
        n_cmp++;
        if ({led_out, active} !== {8'hFF, 1'b1}) begin
            n_fail++; $display("FAIL reset_edge2: got led=%h act=%b want led=ff act=1", led_out, active);
        end
    endtask

    task automatic test_steady_pwm();
        int hi;
        logic [7:0] exp;
        hi = 0;
        pattern_in = 8'h01; bright = 4'd15;
        step(2);
        for (int k = 0; k < 64; k++) begin
            step(1);
            exp = (pwm_prev() != 15) ? 8'h01 : 8'h00;
            if (led_out[0]) hi++;
            n_cmp++;
            if (led_out !== exp) begin
                n_fail++; $display("FAIL steady_pwm[%0d]: got %h want %h", k, led_out, exp);
            end
        end
        n_cmp++;
        if (hi != 60) begin
            n_fail++; $display("FAIL steady_duty_count: got %0d want 60", hi);
        end
    endtask

    task automatic test_fade();
        int first14, zero_at;
        logic rose;
        logic [3:0] d, prev;
        first14 = -1; zero_at = -1; rose = 1'b0; prev = 4'd15;
        fade_en = 1'b1; pattern_in = 8'h00;
        for (int k = 1; k <= 100; k++) begin
            step(1);
            d = dut.g_chan[0].u_chan.r_duty;
            if (d > prev) rose = 1'b1;
            if (d == 4'd14 && first14 < 0) first14 = k;
            prev = d;
            if (d == 4'd0) begin
                zero_at = k;
                break;
            end
        end
        n_cmp++;
        if (zero_at < 57 || zero_at > 60) begin
            n_fail++; $display("FAIL fade_duration: got %0d want 57..60", zero_at);
        end
        n_cmp++;
        if (first14 < 1 || first14 > 4 || zero_at - first14 != 56) begin
            n_fail++; $display("FAIL fade_rate: got first=%0d zero=%0d want first 1..4, span 56", first14, zero_at);
        end
        n_cmp++;
        if (rose !== 1'b0) begin
            n_fail++; $display("FAIL fade_monotonic: got rise=%b want 0", rose);
        end
        n_cmp++;
        if (active !== 1'b1) begin
            n_fail++; $display("FAIL fade_active_hold: got %b want 1", active);
        end
        step(1);
        n_cmp++;
        if (active !== 1'b0) begin
            n_fail++; $display("FAIL fade_active_fall: got %b want 0", active);
        end
        step(8);
        n_cmp++;
        if ({dut.g_chan[0].u_chan.r_duty, led_out} !== 12'h000) begin
            n_fail++; $display("FAIL fade_no_wrap: got duty=%0d led=%h want 0/00",
                               dut.g_chan[0].u_chan.r_duty, led_out);
        end
    endtask

    task automatic test_hard_off();
        logic [7:0] exp;
        fade_en = 1'b0; pattern_in = 8'h01; bright = 4'd15;
        step(3);
        pattern_in = 8'h00;
        step(1);
        n_cmp++;
        if (dut.g_chan[0].u_chan.r_duty !== 4'd0) begin
            n_fail++; $display("FAIL hard_off_duty: got %0d want 0", dut.g_chan[0].u_chan.r_duty);
        end
        exp = (pwm_prev() != 15) ? 8'h01 : 8'h00;
        n_cmp++;
        if (led_out !== exp) begin
            n_fail++; $display("FAIL hard_off_edge1: got %h want %h", led_out, exp);
        end
        for (int k = 0; k < 16; k++) begin
            step(1);
            n_cmp++;
            if (led_out !== 8'h00) begin
                n_fail++; $display("FAIL hard_off_led[%0d]: got %h want 00", k, led_out);
            end
        end
    endtask

    task automatic test_saturation();
        int changes;
        logic [3:0] d, prev;
        changes = 0;
        pattern4 = 8'h01; bright4 = 4'd6;
        step(2);
        prev = dut4.g_chan[0].u_chan.r_duty;
        n_cmp++;
        if (prev !== 4'd6) begin
            n_fail++; $display("FAIL sat_load: got %0d want 6", prev);
        end
        pattern4 = 8'h00;
        for (int k = 0; k < 40; k++) begin
            step(1);
            d = dut4.g_chan[0].u_chan.r_duty;
            if (d !== prev) begin
                changes++;
                n_cmp++;
                if (changes == 1 && d !== 4'd2) begin
                    n_fail++; $display("FAIL sat_step1: got %0d want 2", d);
                end else if (changes == 2 && d !== 4'd0) begin
                    n_fail++; $display("FAIL sat_step2: got %0d want 0", d);
                end else if (changes > 2) begin
                    n_fail++; $display("FAIL sat_extra_change: got %0d want 0", d);
                end
            end
            prev = d;
        end
        n_cmp++;
        if (changes != 2 || prev !== 4'd0) begin
            n_fail++; $display("FAIL sat_final: got changes=%0d duty=%0d want 2/0", changes, prev);
        end
    endtask

    task automatic test_brightness();
        int hi;
        logic [7:0] exp;
        hi = 0;
        fade_en = 1'b0; bright = 4'd0; pattern_in = 8'hFF;
        step(2);
        for (int k = 0; k < 16; k++) begin
            step(1);
            n_cmp++;
            if ({led_out, active} !== 9'h000) begin
                n_fail++; $display("FAIL bright0[%0d]: got led=%h act=%b want 00/0", k, led_out, active);
            end
        end
        bright = 4'd4;
        step(1);
        n_cmp++;
        if (dut.g_chan[5].u_chan.r_duty !== 4'd4) begin
            n_fail++; $display("FAIL bright_track: got %0d want 4", dut.g_chan[5].u_chan.r_duty);
        end
        for (int k = 0; k < 16; k++) begin
            step(1);
            exp = (pwm_prev() < 4) ? 8'hFF : 8'h00;
            if (led_out[0]) hi++;
            n_cmp++;
            if (led_out !== exp) begin
                n_fail++; $display("FAIL bright4[%0d]: got %h want %h", k, led_out, exp);
            end
        end
        n_cmp++;
        if (hi != 4 || active !== 1'b1) begin
            n_fail++; $display("FAIL bright4_count: got hi=%0d act=%b want 4/1", hi, active);
        end
    endtask

    task automatic test_retrigger();
        logic found;
        logic exp;
        found = 1'b0;
        fade_en = 1'b1; bright = 4'd15; pattern_in = 8'h08;
        step(2);
        pattern_in = 8'h00;
        for (int k = 0; k < 80; k++) begin
            step(1);
            if (dut.g_chan[3].u_chan.r_duty == 4'd7) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (found !== 1'b1) begin
            n_fail++; $display("FAIL retrig_reach7: got found=%b want 1", found);
        end
        // Three edges after the decrement to 7, the next edge carries a tick.
        step(3);
        n_cmp++;
        if ({dut.g_chan[3].u_chan.r_duty, dut.w_tick} !== {4'd7, 1'b1}) begin
            n_fail++; $display("FAIL retrig_pre: got duty=%0d tick=%b want 7/1",
                               dut.g_chan[3].u_chan.r_duty, dut.w_tick);
        end
        pattern_in = 8'h08; bright = 4'd12;
        step(1);
        n_cmp++;
        if (dut.g_chan[3].u_chan.r_duty !== 4'd12) begin
            n_fail++; $display("FAIL retrig_load: got %0d want 12", dut.g_chan[3].u_chan.r_duty);
        end
        step(1);
        exp = (pwm_prev() < 12);
        n_cmp++;
        if (led_out !== {4'b0, exp, 3'b0}) begin
            n_fail++; $display("FAIL retrig_led: got %h want %h", led_out, {4'b0, exp, 3'b0});
        end
    endtask

    initial begin
        test_reset();
        test_steady_pwm();
        test_fade();
        test_hard_off();
        test_saturation();
        test_brightness();
        test_retrigger();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
